// File: rtl/pipe_ctrl.sv
// Pipeline control: turns EX jump/hold and bus stall into PC redirect, hold and flush controls.
// Outputs are combinational from state and inputs (0-cycle); a jump seen during a stall is deferred until hold clears.
module pipe_ctrl #(
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      jump_addr_i,
  input  logic             jump_en_i,
  input  logic             hold_flag_i,
  input  logic             bus_hold_i,
  output logic [31:0]      jump_addr_o,
  output logic             jump_en_o,
  output logic             hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic [CNT_W-1:0] jump_cnt_o,
  output logic [CNT_W-1:0] hold_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    PEND  = 2'd2
  } state_t;

  localparam logic [2:0] FE = 3'(FLUSH_EXTRA);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] jump_cnt_q, hold_cnt_q;

  logic        hold_any;
  logic        redirect;
  logic        flush;
  logic [31:0] redir_addr;

  assign hold_any = hold_flag_i | bus_hold_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    redirect   = 1'b0;
    flush      = 1'b0;
    redir_addr = 32'd0;
    case (state_q)
      IDLE: begin
        if (jump_en_i) begin
          if (!hold_any) begin
            redirect   = 1'b1;
            redir_addr = jump_addr_i;
            flush      = 1'b1;
            if (FE != 3'd0) begin
              state_d = FLUSH;
              cnt_d   = FE;
            end
          end else begin
            // Stalled: remember the target, EX keeps presenting the same instruction.
            addr_d  = jump_addr_i;
            state_d = PEND;
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (!hold_any) begin
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      PEND: begin
        if (!hold_any) begin
          redirect   = 1'b1;
          redir_addr = addr_q;
          flush      = 1'b1;
          cnt_d      = FE;
          state_d    = (FE != 3'd0) ? FLUSH : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 32'd0;
      jump_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      jump_cnt_q <= jump_cnt_q + {{(CNT_W-1){1'b0}}, redirect};
      hold_cnt_q <= hold_cnt_q + {{(CNT_W-1){1'b0}}, hold_any};
    end
  end

  // Reset gates every output combinationally so nothing escapes during the reset window.
  assign jump_en_o     = redirect & ~rst;
  assign jump_addr_o   = (redirect & ~rst) ? redir_addr : 32'd0;
  assign hold_o        = hold_any & ~rst;
  assign if_id_flush_o = flush & ~rst;
  assign id_ex_flush_o = flush & ~rst;
  assign jump_cnt_o    = jump_cnt_q;
  assign hold_cnt_o    = hold_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three instances (FLUSH_EXTRA=1, 2, 0 with a 4-bit counter) on shared stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] jump_addr_i;
  logic        jump_en_i, hold_flag_i, bus_hold_i;

  typedef struct packed {
    logic        jen;
    logic [31:0] addr;
    logic        hold;
    logic        ifl;
    logic        idf;
  } obs_t;

  logic [31:0] a1, a2, a0;
  logic        j1, j2, j0, h1, h2, h0, f1, f2, f0, g1, g2, g0;
  logic [31:0] jc1, hc1, jc2, hc2;
  logic [3:0]  jc0, hc0;

  pipe_ctrl #(.FLUSH_EXTRA(1), .CNT_W(32)) u_fe1 (
    .clk(clk), .rst(rst), .jump_addr_i(jump_addr_i), .jump_en_i(jump_en_i),
    .hold_flag_i(hold_flag_i), .bus_hold_i(bus_hold_i), .jump_addr_o(a1),
    .jump_en_o(j1), .hold_o(h1), .if_id_flush_o(f1), .id_ex_flush_o(g1),
    .jump_cnt_o(jc1), .hold_cnt_o(hc1));

  pipe_ctrl #(.FLUSH_EXTRA(2), .CNT_W(32)) u_fe2 (
    .clk(clk), .rst(rst), .jump_addr_i(jump_addr_i), .jump_en_i(jump_en_i),
    .hold_flag_i(hold_flag_i), .bus_hold_i(bus_hold_i), .jump_addr_o(a2),
    .jump_en_o(j2), .hold_o(h2), .if_id_flush_o(f2), .id_ex_flush_o(g2),
    .jump_cnt_o(jc2), .hold_cnt_o(hc2));

  pipe_ctrl #(.FLUSH_EXTRA(0), .CNT_W(4)) u_fe0 (
    .clk(clk), .rst(rst), .jump_addr_i(jump_addr_i), .jump_en_i(jump_en_i),
    .hold_flag_i(hold_flag_i), .bus_hold_i(bus_hold_i), .jump_addr_o(a0),
    .jump_en_o(j0), .hold_o(h0), .if_id_flush_o(f0), .id_ex_flush_o(g0),
    .jump_cnt_o(jc0), .hold_cnt_o(hc0));

  always #5 clk = ~clk;

  int   sel;
  obs_t obs;
  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always_comb begin
    obs = '0;
    case (sel)
      1:       obs = '{jen: j1, addr: a1, hold: h1, ifl: f1, idf: g1};
      2:       obs = '{jen: j2, addr: a2, hold: h2, ifl: f2, idf: g2};
      default: obs = '{jen: j0, addr: a0, hold: h0, ifl: f0, idf: g0};
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive, queue expectation, compare mid-cycle, advance one edge.
  task automatic cyc(input string tag, input logic je, input logic [31:0] ja,
                     input logic hf, input logic bh,
                     input logic ejen, input logic [31:0] eaddr,
                     input logic ehold, input logic efl);
    obs_t e;
    jump_en_i   = je;
    jump_addr_i = ja;
    hold_flag_i = hf;
    bus_hold_i  = bh;
    exp_q.push_back('{jen: ejen, addr: eaddr, hold: ehold, ifl: efl, idf: efl});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".jen"},   64'(obs.jen),  64'(e.jen));
    chk({tag, ".addr"},  64'(obs.addr), 64'(e.addr));
    chk({tag, ".hold"},  64'(obs.hold), 64'(e.hold));
    chk({tag, ".ifl"},   64'(obs.ifl),  64'(e.ifl));
    chk({tag, ".idf"},   64'(obs.idf),  64'(e.idf));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_en_i = 1'b0; jump_addr_i = 32'd0; hold_flag_i = 1'b0; bus_hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1;
    do_reset();

    // Reset asserted mid-cycle while a jump is being requested.
    jump_en_i = 1'b1; jump_addr_i = 32'h40; hold_flag_i = 1'b0; bus_hold_i = 1'b0;
    #2;
    chk("pre_rst.jen", 64'(j1), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst.jen",  64'(j1), 64'd0);
    chk("rst.addr", 64'(a1), 64'd0);
    chk("rst.ifl",  64'(f1), 64'd0);
    chk("rst.idf",  64'(g1), 64'd0);
    hold_flag_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold.hold", 64'(h1), 64'd0);
    chk("rst_hold.jen",  64'(j1), 64'd0);
    chk("rst_hold.addr", 64'(a1), 64'd0);
    rst = 1'b0;
    cyc("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst.jcnt", 64'(jc1), 64'd0);
    chk("post_rst.hcnt", 64'(hc1), 64'd0);

    // Plain jump, one extra flush cycle.
    do_reset();
    cyc("jmp0", 1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
    cyc("jmp1", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1);
    cyc("jmp2", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
    chk("jmp.jcnt", 64'(jc1), 64'd1);
    chk("jmp.hcnt", 64'(hc1), 64'd0);

    // Jump during a 3-cycle bus stall; redirect must use the latched target.
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc("stall", 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall.hcnt", 64'(hc1), 64'd3);
    chk("stall.jcnt", 64'(jc1), 64'd0);
    cyc("pend_go", 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    cyc("pend_fl", 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1);
    cyc("pend_dn", 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0);
    chk("pend.jcnt", 64'(jc1), 64'd1);
    chk("pend.hcnt", 64'(hc1), 64'd3);

    // Hold inside FLUSH with two extra flush cycles; jump_en_i ignored there.
    sel = 2;
    do_reset();
    cyc("fh_jmp", 1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1);
    cyc("fh_h0",  1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1);
    cyc("fh_h1",  1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1);
    cyc("fh_c2",  1'b1, 32'h90, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1);
    cyc("fh_c1",  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1);
    cyc("fh_dn",  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
    chk("fh.jcnt", 64'(jc2), 64'd1);
    chk("fh.hcnt", 64'(hc2), 64'd2);

    // No extra flush: back-to-back jumps, then a deferred jump.
    sel = 0;
    do_reset();
    cyc("b2b0", 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1);
    cyc("b2b1", 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1);
    cyc("b2b2", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
    chk("b2b.jcnt", 64'(jc0), 64'd2);
    cyc("p0_st", 1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0);
    cyc("p0_go", 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b1);
    cyc("p0_dn", 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0);
    chk("p0.jcnt", 64'(jc0), 64'd3);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 15; i++)
      cyc("wrap_j", 1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b1);
    chk("wrap.jcnt_max", 64'(jc0), 64'hF);
    cyc("wrap_j15", 1'b1, 32'h3C, 1'b0, 1'b0, 1'b1, 32'h3C, 1'b0, 1'b1);
    chk("wrap.jcnt_zero", 64'(jc0), 64'd0);
    for (int i = 0; i < 15; i++)
      cyc("wrap_h", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap.hcnt_max", 64'(hc0), 64'hF);
    cyc("wrap_h15", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap.hcnt_zero", 64'(hc0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
